dvi_timing_gen: RTL and testbench
=================================

# dvi_timing_gen

Video timing generator for the DVI output path. It produces the raster counters, horizontal/vertical sync, data-enable and control pair consumed by the three TMDS encoder channels. It also produces the pixel coordinates consumed by the pixel/sprite logic. All outputs are registered, so the encoders and pixel logic see a common, aligned timing reference.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync (0 = active-low)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; synchronous, active-low
- x  out  10  horizontal counter h_cnt, registered
- y  out  10  vertical counter v_cnt, registered
- hsync  out  1  horizontal sync at HSYNC_POL polarity
- vsync  out  1  vertical sync at VSYNC_POL polarity
- de  out  1  video data enable (active region)
- ctrl  out  2  {vsync, hsync}, blue-channel encoder control
- line_start  out  1  one-cycle pulse when h_cnt == 0
- frame_start  out  1  one-cycle pulse when h_cnt == 0 and v_cnt == 0
- frame_count  out  8  completed-frame counter, wraps 255 -> 0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Both totals must be ≤ 1024. Elaboration fails (generate-time error) otherwise.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0.
- v_cnt increments when h_cnt wraps, runs 0..V_TOTAL-1, and wraps to 0 at the end of the frame.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE; de = 1 only there.
- hsync is asserted for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751. Otherwise it is at ~HSYNC_POL.
- vsync is asserted for V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. lines 490..491, for the whole line. Otherwise it is at ~VSYNC_POL.
- frame_count increments (mod 256) on the edge where h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1.
- x/y are raw counters, not gated by de. Consumers must qualify x/y with de.
- Counters have no idle or stall state; the block free-runs whenever rst_n = 1.

## Timing
- Reset applies on any rising clk edge with rst_n = 0, including mid-frame. Reset state:
  - h_cnt = 0, v_cnt = 0, x = 0, y = 0
  - de = 0, line_start = 0, frame_start = 0, frame_count = 0
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL, ctrl = {~VSYNC_POL, ~HSYNC_POL}
- Every output is a register loaded from the counter state before the edge, giving one-cycle latency from counter to output.
- Edge 1 is the first edge with rst_n = 1. After edge 1:
  - outputs reflect (0,0): de = 1, x = 0, y = 0, line_start = 1, frame_start = 1
  - counters advance to (1,0)
- x, y, de, hsync, vsync, ctrl, line_start and frame_start all change on the same edge. There is no skew between them.
- frame_count changes on the same edge where outputs show the last pixel (799,524).
- It therefore reads 1 together with the second frame_start, and every subsequent frame_start presents the updated count.
- Simultaneous end-of-line and end-of-frame: h_cnt and v_cnt both wrap to 0 on one edge. v_cnt never shows V_TOTAL.
- Period: line_start every H_TOTAL cycles; frame_start every H_TOTAL·V_TOTAL cycles (420000 at defaults).

## Test plan
- Reset: hold rst_n = 0 for 5 cycles.
  - Required: all outputs at reset values (hsync = 1, vsync = 1, ctrl = 2'b11, de = 0, frame_count = 0).
  - After release: the first edge gives de = 1, frame_start = 1, x = 0, y = 0.
- Line timing (defaults), first line after reset:
  - de high for exactly 640 consecutive cycles (x = 0..639).
  - hsync low exactly while x = 656..751 (96 cycles).
  - line_start pulses at x = 0 only; next line_start 800 cycles later with y = 1.
- Frame timing:
  - vsync low exactly for y = 490..491 (1600 cycles); de = 0 for all y ≥ 480.
  - Second frame_start 420000 cycles after the first, with frame_count = 1 and x = y = 0.
- Wrap-around: use small parameters (H 4/1/2/1, V 3/1/1/1, H_TOTAL = 8, V_TOTAL = 6).
  - Run 256·48 + 48 cycles.
  - Required: frame_count wraps 255 -> 0; v_cnt never reaches 6; h_cnt never reaches 8.
- Reset mid-operation: assert rst_n = 0 for one edge at x = 700, y = 300.
  - Required: reset values on the next edge.
  - Restart at (0,0) one edge after release; frame_count = 0.
- Polarity: HSYNC_POL = 1, VSYNC_POL = 1.
  - Required: reset hsync = vsync = 0; hsync = 1 exactly for x = 656..751; ctrl = {vsync, hsync} on every cycle.

Source files
------------

// File: rtl/dvi_timing_gen.sv
// Free-running DVI raster timing generator: counters, syncs, data-enable and
// frame bookkeeping, all registered so every output shares one-cycle latency.
module dvi_timing_gen #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [1:0] ctrl,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
        $error("dvi_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
    localparam logic [10:0] H_ACT_W  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_W  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_de;
    logic [1:0] r_ctrl;
    logic       r_line_start;
    logic       r_frame_start;
    logic [7:0] r_frame_count;

    logic       w_h_last;
    logic       w_v_last;
    logic       w_hs_on;
    logic       w_vs_on;
    logic       w_active;
    logic       w_hsync;
    logic       w_vsync;

    always_comb begin
        w_h_last = (r_h_cnt == H_LAST);
        w_v_last = (r_v_cnt == V_LAST);
        w_hs_on  = ({1'b0, r_h_cnt} >= HS_START) && ({1'b0, r_h_cnt} < HS_END);
        w_vs_on  = ({1'b0, r_v_cnt} >= VS_START) && ({1'b0, r_v_cnt} < VS_END);
        w_active = ({1'b0, r_h_cnt} < H_ACT_W) && ({1'b0, r_v_cnt} < V_ACT_W);
        w_hsync  = w_hs_on ? HSYNC_POL : ~HSYNC_POL;
        w_vsync  = w_vs_on ? VSYNC_POL : ~VSYNC_POL;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_de          <= 1'b0;
            r_ctrl        <= {~VSYNC_POL, ~HSYNC_POL};
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_h_cnt <= w_h_last ? '0 : r_h_cnt + 10'd1;
            if (w_h_last) begin
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
            end
            r_x           <= r_h_cnt;
            r_y           <= r_v_cnt;
            r_hsync       <= w_hsync;
            r_vsync       <= w_vsync;
            r_de          <= w_active;
            r_ctrl        <= {w_vsync, w_hsync};
            r_line_start  <= (r_h_cnt == '0);
            r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
            if (w_h_last && w_v_last) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign ctrl        = r_ctrl;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Scoreboard bench: four generator configurations share one clock; expected
// outputs come from a pixel-index model and are queued per edge.
module tb_dvi_timing_gen;

    typedef struct {
        int   ha, hfp, hs, hbp, va, vfp, vs, vbp;
        logic hp, vp;
    } cfg_t;

    localparam int N_CYC   = 12400;
    localparam int MED_MID = 6471;   // edge after which outputs show (70,30) of frame 1

    cfg_t c_def   = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfg_t c_pol   = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b1};
    cfg_t c_med   = '{64, 4, 8, 4, 40, 3, 2, 5, 1'b0, 1'b0};
    cfg_t c_small = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_def = 1'b0, rst_n_pol = 1'b0, rst_n_med = 1'b0, rst_n_small = 1'b0;

    logic [9:0] x_def, y_def, x_pol, y_pol, x_med, y_med, x_small, y_small;
    logic       hs_def, vs_def, de_def, ls_def, fs_def;
    logic       hs_pol, vs_pol, de_pol, ls_pol, fs_pol;
    logic       hs_med, vs_med, de_med, ls_med, fs_med;
    logic       hs_small, vs_small, de_small, ls_small, fs_small;
    logic [1:0] ctrl_def, ctrl_pol, ctrl_med, ctrl_small;
    logic [7:0] fc_def, fc_pol, fc_med, fc_small;

    dvi_timing_gen u_def (
        .clk(clk), .rst_n(rst_n_def), .x(x_def), .y(y_def), .hsync(hs_def), .vsync(vs_def),
        .de(de_def), .ctrl(ctrl_def), .line_start(ls_def), .frame_start(fs_def),
        .frame_count(fc_def)
    );

    dvi_timing_gen #(.HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) u_pol (
        .clk(clk), .rst_n(rst_n_pol), .x(x_pol), .y(y_pol), .hsync(hs_pol), .vsync(vs_pol),
        .de(de_pol), .ctrl(ctrl_pol), .line_start(ls_pol), .frame_start(fs_pol),
        .frame_count(fc_pol)
    );

    dvi_timing_gen #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(40), .V_FP(3), .V_SYNC(2), .V_BP(5)
    ) u_med (
        .clk(clk), .rst_n(rst_n_med), .x(x_med), .y(y_med), .hsync(hs_med), .vsync(vs_med),
        .de(de_med), .ctrl(ctrl_med), .line_start(ls_med), .frame_start(fs_med),
        .frame_count(fc_med)
    );

    dvi_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_small (
        .clk(clk), .rst_n(rst_n_small), .x(x_small), .y(y_small), .hsync(hs_small),
        .vsync(vs_small), .de(de_small), .ctrl(ctrl_small), .line_start(ls_small),
        .frame_start(fs_small), .frame_count(fc_small)
    );

    logic [34:0] o_def, o_pol, o_med, o_small;
    assign o_def   = {fc_def, ctrl_def, fs_def, ls_def, de_def, vs_def, hs_def, y_def, x_def};
    assign o_pol   = {fc_pol, ctrl_pol, fs_pol, ls_pol, de_pol, vs_pol, hs_pol, y_pol, x_pol};
    assign o_med   = {fc_med, ctrl_med, fs_med, ls_med, de_med, vs_med, hs_med, y_med, x_med};
    assign o_small = {fc_small, ctrl_small, fs_small, ls_small, de_small, vs_small, hs_small,
                      y_small, x_small};

    logic [34:0] q_def[$], q_pol[$], q_med[$], q_small[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // p = index of the pixel shown after the edge; p < 0 means the edge was in reset
    function automatic logic [34:0] expect_out(input cfg_t c, input int p);
        int   ht, vt, px, py, fc;
        logic h, v, d;
        ht = c.ha + c.hfp + c.hs + c.hbp;
        vt = c.va + c.vfp + c.vs + c.vbp;
        if (p < 0) return {8'd0, ~c.vp, ~c.hp, 3'b000, ~c.vp, ~c.hp, 20'd0};
        px = p % ht;
        py = (p / ht) % vt;
        fc = ((p + 1) / (ht * vt)) % 256;
        h  = (px >= c.ha + c.hfp && px < c.ha + c.hfp + c.hs) ? c.hp : ~c.hp;
        v  = (py >= c.va + c.vfp && py < c.va + c.vfp + c.vs) ? c.vp : ~c.vp;
        d  = (px < c.ha) && (py < c.va);
        return {8'(fc), v, h, (px == 0 && py == 0), (px == 0), d, v, h, 10'(py), 10'(px)};
    endfunction

    int   n_def = 0, n_pol = 0, n_med = 0, n_small = 0;
    int   de_cnt = 0, hs_cnt = 0, hs_first = -1, hs_last = -1, ls_cnt = 0;
    int   ph_cnt = 0, ph_first = -1, ph_last = -1;
    int   vs_cnt = 0, vs_ymin = 1024, vs_ymax = -1, de_bad = 0;
    int   max_x_small = 0, max_y_small = 0;
    logic [7:0] prev_fc_small = 8'd0;
    logic wrap_seen = 1'b0;
    logic med_mid = 1'b0, med_mid_done = 1'b0;

    initial begin
        for (int c = 0; c < N_CYC; c++) begin
            @(negedge clk);
            med_mid     = !med_mid_done && (n_med == MED_MID);
            rst_n_def   = (c >= 5);
            rst_n_pol   = (c >= 5);
            rst_n_small = (c >= 5);
            rst_n_med   = (c >= 5) && !med_mid;
            n_def   = rst_n_def   ? n_def + 1   : 0;
            n_pol   = rst_n_pol   ? n_pol + 1   : 0;
            n_med   = rst_n_med   ? n_med + 1   : 0;
            n_small = rst_n_small ? n_small + 1 : 0;
            q_def.push_back(expect_out(c_def, n_def - 1));
            q_pol.push_back(expect_out(c_pol, n_pol - 1));
            q_med.push_back(expect_out(c_med, n_med - 1));
            q_small.push_back(expect_out(c_small, n_small - 1));

            @(posedge clk);
            #1;
            check_eq("sb_def",   64'(o_def),   64'(q_def.pop_front()));
            check_eq("sb_pol",   64'(o_pol),   64'(q_pol.pop_front()));
            check_eq("sb_med",   64'(o_med),   64'(q_med.pop_front()));
            check_eq("sb_small", 64'(o_small), 64'(q_small.pop_front()));
            check_eq("pol_ctrl", 64'(ctrl_pol), 64'({vs_pol, hs_pol}));

            if (c == 4) begin
                check_eq("rst_hsync", 64'(hs_def), 64'd1);
                check_eq("rst_vsync", 64'(vs_def), 64'd1);
                check_eq("rst_ctrl",  64'(ctrl_def), 64'd3);
                check_eq("rst_de",    64'(de_def), 64'd0);
                check_eq("rst_fc",    64'(fc_def), 64'd0);
                check_eq("rst_pol_syncs", 64'({vs_pol, hs_pol, ctrl_pol}), 64'd0);
            end

            if (n_def == 1 && c == 5) begin
                check_eq("edge1_de_fs", 64'({de_def, fs_def, ls_def}), 64'h7);
                check_eq("edge1_xy",    64'({y_def, x_def}), 64'd0);
            end
            if (n_def >= 1 && n_def <= 800) begin
                if (de_def) de_cnt++;
                if (ls_def) ls_cnt++;
                if (!hs_def) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(x_def);
                    hs_last = int'(x_def);
                end
                if (hs_pol) begin
                    ph_cnt++;
                    if (ph_first < 0) ph_first = int'(x_pol);
                    ph_last = int'(x_pol);
                end
            end
            if (n_def == 801) begin
                check_eq("line_de_cnt",   64'(de_cnt), 64'd640);
                check_eq("line_hs_cnt",   64'(hs_cnt), 64'd96);
                check_eq("line_hs_range", 64'({hs_first, hs_last}), {32'd656, 32'd751});
                check_eq("line_ls_cnt",   64'(ls_cnt), 64'd1);
                check_eq("line2_start",   64'({ls_def, y_def, x_def}), 64'({1'b1, 10'd1, 10'd0}));
                check_eq("pol_hs_cnt",    64'(ph_cnt), 64'd96);
                check_eq("pol_hs_range",  64'({ph_first, ph_last}), {32'd656, 32'd751});
            end

            if (!med_mid_done && n_med >= 1 && n_med <= 4000) begin
                if (!vs_med) begin
                    vs_cnt++;
                    if (int'(y_med) < vs_ymin) vs_ymin = int'(y_med);
                    if (int'(y_med) > vs_ymax) vs_ymax = int'(y_med);
                end
                if (de_med && y_med >= 10'd40) de_bad++;
            end
            if (!med_mid_done && n_med == 4000) begin
                check_eq("frm_vs_cnt",   64'(vs_cnt), 64'd160);
                check_eq("frm_vs_range", 64'({vs_ymin, vs_ymax}), {32'd43, 32'd44});
                check_eq("frm_de_blank", 64'(de_bad), 64'd0);
            end
            if (!med_mid_done && n_med == 4001) begin
                check_eq("frm2_start", 64'({fs_med, fc_med, y_med, x_med}),
                         64'({1'b1, 8'd1, 10'd0, 10'd0}));
            end
            if (!med_mid_done && n_med == MED_MID) begin
                check_eq("mid_pos", 64'({fc_med, y_med, x_med}), 64'({8'd1, 10'd30, 10'd70}));
            end
            if (med_mid) begin
                check_eq("mid_rst", 64'({de_med, fs_med, fc_med, y_med, x_med}), 64'd0);
                med_mid_done = 1'b1;
            end else if (med_mid_done && n_med == 1) begin
                check_eq("mid_restart", 64'({fs_med, fc_med, y_med, x_med}),
                         64'({1'b1, 8'd0, 10'd0, 10'd0}));
            end

            if (int'(x_small) > max_x_small) max_x_small = int'(x_small);
            if (int'(y_small) > max_y_small) max_y_small = int'(y_small);
            if (prev_fc_small == 8'd255 && fc_small == 8'd0) wrap_seen = 1'b1;
            prev_fc_small = fc_small;
        end

        check_eq("small_fc_wrap", 64'(wrap_seen), 64'd1);
        check_eq("small_max_x",   64'(max_x_small), 64'd7);
        check_eq("small_max_y",   64'(max_y_small), 64'd5);
        check_eq("mid_rst_done",  64'(med_mid_done), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
